// File: rtl/round_key_loader.sv
// Round key loader: collects 24 round keys of 48 bits from the key-expansion
// unit into a packed bank. It then serves that bank to a consumer as four groups
// of six keys. The consumer advances through the groups with a step pulse.
//
// Handshake on the key input: a key is transferred on a rising edge where
// key_valid and key_ready are both 1. key_ready depends only on the state and
// on rst, never on key_valid. The producer may hold or change key_in freely
// while key_ready is 0.
module round_key_loader (
    input  logic           clk,
    input  logic           rst,
    input  logic [47:0]    key_in,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic           step,
    output logic [1151:0]  round_keys,
    output logic [1:0]     count,
    output logic           keys_full,
    output logic           group_done,
    output logic           fsm_state
);

    typedef enum logic {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  idx;
    logic        accept;
    logic        last_key;
    logic        last_group;
    logic [10:0] slot_base;

    // Handshake, slot address and next-state decode.
    // key_ready is 0 during reset, so a key cannot be accepted in that cycle.
    always_comb begin
        next_state = state;
        key_ready  = (state == LOAD) && !rst;
        keys_full  = (state == SERVE);
        accept     = key_valid && key_ready;
        last_key   = (idx == 5'd23);
        last_group = (state == SERVE) && step && (count == 2'd3);
        // Key k is stored at the top of the bus, so slot k starts at bit 48*(23-k).
        slot_base  = 11'(5'd23 - idx) * 11'd48;
        case (state)
            LOAD:    if (accept && last_key) next_state = SERVE;
            SERVE:   if (last_group)         next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Expose the FSM state for observation.
    always_comb begin
        fsm_state = state;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    // Load index and key bank. The bank is not cleared between loads.
    // A new load overwrites the slots in index order.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 5'd0;
            round_keys <= '0;
        end else if (accept) begin
            round_keys[slot_base +: 48] <= key_in;
            idx <= last_key ? 5'd0 : idx + 5'd1;
        end
    end

    // Group counter and end-of-bank pulse. Steps in LOAD are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            group_done <= 1'b0;
        end else begin
            group_done <= last_group;
            if (state == SERVE && step) begin
                count <= (count == 2'd3) ? 2'd0 : count + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_round_key_loader.sv
// Bench for round_key_loader: directed scenarios plus randomized traffic.
// Every cycle is compared against a behavioural model of the key bank.
module tb_round_key_loader;

    logic           clk = 1'b0;
    logic           rst;
    logic [47:0]    key_in;
    logic           key_valid;
    logic           key_ready;
    logic           step;
    logic [1151:0]  round_keys;
    logic [1:0]     count;
    logic           keys_full;
    logic           group_done;
    logic           fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    round_key_loader dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .step(step), .round_keys(round_keys),
        .count(count), .keys_full(keys_full), .group_done(group_done),
        .fsm_state(fsm_state)
    );

    // Clock: period 10.
    always #5 clk = ~clk;

    // Behavioural model: a list of 24 keys, a fill counter, a serving flag and a group number.
    logic [47:0] m_bank [24];
    int  m_n    = 0;
    bit  m_serve = 1'b0;
    int  m_grp  = 0;
    bit  m_done = 1'b0;
    bit  chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 24; s++) m_bank[s] = '0;
            m_n = 0; m_serve = 0; m_grp = 0; m_done = 0;
            chk_on = 1'b1;
        end else begin
            m_done = 0;
            if (!m_serve) begin
                if (key_valid) begin
                    m_bank[m_n] = key_in;
                    m_n = m_n + 1;
                    if (m_n == 24) begin m_n = 0; m_serve = 1; end
                end
            end else if (step) begin
                if (m_grp == 3) begin m_grp = 0; m_serve = 0; m_done = 1; end
                else m_grp = m_grp + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("key_ready", 64'(key_ready), 64'(!m_serve && !rst));
            check("keys_full", 64'(keys_full), 64'(m_serve));
            check("count", 64'(count), 64'(m_grp));
            check("group_done", 64'(group_done), 64'(m_done));
            check("ready_full_excl", 64'(key_ready & keys_full), 64'd0);
            for (int s = 0; s < 24; s++)
                check($sformatf("slot%0d", s), 64'(round_keys[1151 - 48*s -: 48]), 64'(m_bank[s]));
        end
    end

    // Drive inputs for one cycle. The values are applied 2 time units after a rising edge.
    task automatic tick(input logic r, input logic kv, input logic [47:0] k, input logic st);
        rst = r; key_valid = kv; key_in = k; step = st;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[47:0];
    endfunction

    task automatic load_full();
        for (int i = 0; i < 24; i++) tick(0, 1, rnd48(), 0);
    endtask

    logic [47:0] first_key;

    initial begin
        rst = 1; key_valid = 0; key_in = '0; step = 0;
        tick(1, 0, 0, 0);
        tick(1, 1, 48'h123, 1);

        // Back-to-back stream of keys with values 1..24.
        for (int i = 0; i < 24; i++) begin
            tick(0, 1, 48'(i + 1), 0);
            if (i == 22) check("full_before_24th", 64'(keys_full), 64'd0);
        end
        check("full_after_24th", 64'(keys_full), 64'd1);
        check("top_slot_lit", 64'(round_keys[1151:1104]), 64'd1);
        check("bottom_slot_lit", 64'(round_keys[47:0]), 64'd24);
        check("count_lit0", 64'(count), 64'd0);
        check("ready_lit0", 64'(key_ready), 64'd0);

        // Keys offered in SERVE must not be written.
        for (int i = 0; i < 3; i++) tick(0, 1, 48'hFFFF_FFFF_FFFF, 0);
        check("serve_no_write", 64'(round_keys[1151:1104]), 64'd1);

        // Four steps separated by gaps.
        for (int j = 0; j < 4; j++) begin
            tick(0, 0, 0, 1);
            check("step_count_lit", 64'(count), 64'((j + 1) % 4));
            if (j == 3) begin
                check("done_pulse_lit", 64'(group_done), 64'd1);
                check("ready_after_last", 64'(key_ready), 64'd1);
            end
            tick(0, 0, 0, 0);
            check("done_gap_lit", 64'(group_done), 64'd0);
        end

        // Steps in LOAD are ignored.
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        check("load_step_count", 64'(count), 64'd0);
        check("load_step_done", 64'(group_done), 64'd0);

        // Randomly gated load with random steps, bounded number of cycles.
        for (int c = 0; c < 200 && !m_serve; c++)
            tick(0, 1'($urandom_range(0, 1)), rnd48(), 1'($urandom_range(0, 1)));
        check("random_load_done", 64'(keys_full), 64'd1);
        for (int c = 0; c < 40; c++)
            tick(0, 1'($urandom_range(0, 1)), rnd48(), 1'($urandom_range(0, 3) == 0));

        // Reset part-way through a load, then load 24 fresh keys.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, rnd48(), 0);
        tick(1, 1, rnd48(), 0);
        first_key = rnd48();
        tick(0, 1, first_key, 0);
        for (int i = 1; i < 24; i++) begin
            tick(0, 1, rnd48(), 0);
            if (i == 22) check("fresh_not_full", 64'(keys_full), 64'd0);
        end
        check("fresh_full", 64'(keys_full), 64'd1);
        check("fresh_top_slot", 64'(round_keys[1151:1104]), 64'(first_key));

        // Reset together with a step while in SERVE at count 2.
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("count_two", 64'(count), 64'd2);
        tick(1, 0, 0, 1);
        check("rst_serve_count", 64'(count), 64'd0);
        check("rst_serve_full", 64'(keys_full), 64'd0);
        check("rst_serve_done", 64'(group_done), 64'd0);
        tick(0, 0, 0, 0);
        check("rst_serve_done2", 64'(group_done), 64'd0);
        check("rst_serve_ready", 64'(key_ready), 64'd1);

        // Mixed random traffic with occasional resets.
        for (int c = 0; c < 300; c++)
            tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), rnd48(),
                 1'($urandom_range(0, 1)));
        tick(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/round_key_loader.md
ROUND_KEY_LOADER -- requirements
Module: round_key_loader

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 48-bit round key, 24 keys, 1152-bit packed bus.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_in  input  48  one round key from the key-expansion unit.
REQ-005 key_valid  input  1  key_in holds a valid key this cycle.
REQ-006 key_ready  output  1  block accepts key_in this cycle.
REQ-007 step  input  1  consumer pulse: current 6-key group used, advance to next group.
REQ-008 round_keys  output  1152  packed bank of 24 round keys, drives the 6-key group selector.
REQ-009 count  output  2  group index for the selector, 0..3.
REQ-010 keys_full  output  1  bank holds 24 keys; round_keys and count are valid.
REQ-011 group_done  output  1  one-cycle pulse when the last group (count 3) is consumed.

Function
REQ-012 Two states, LOAD and SERVE; reset enters LOAD.
REQ-013 LOAD: key_ready=1, keys_full=0; key accepted when key_valid and key_ready are both 1 on a rising edge.
REQ-014 Load index idx (5 bits, 0..23) starts at 0 and increments by 1 per accepted key.
REQ-015 Key accepted at idx=k SHALL be written to round_keys[1151-48k : 1104-48k]; first key lands in [1151:1104], 24th in [47:0]; other slots unchanged.
REQ-016 Acceptance at idx=23 SHALL move to SERVE on the same edge; idx returns to 0; count=0.
REQ-017 SERVE: key_ready=0, keys_full=1; key_valid ignored and no slot written.
REQ-018 SERVE: step=1 with count<3 SHALL increment count by 1 on that edge.
REQ-019 SERVE: step=1 with count=3 SHALL set count=0, return to LOAD, and pulse group_done high for the following cycle only.
REQ-020 key_ready SHALL be 1 in the cycle after the final step (combinational from state, no extra bubble).
REQ-021 step in LOAD SHALL be ignored: count stays 0, no pulse.
REQ-022 round_keys SHALL hold its contents after leaving SERVE; LOAD overwrites slots in index order, and the bus is not cleared between loads.
REQ-023 count SHALL hold 0 throughout LOAD and never exceed 3.
REQ-024 key_ready and keys_full SHALL be mutually exclusive in every cycle after reset.
REQ-025 Load-to-SERVE latency: keys_full rises on the edge accepting the 24th key; with back-to-back key_valid, 24 cycles from the first accepted key.

Reset
REQ-026 rst=1 on a rising edge SHALL force: state LOAD, idx=0, count=0, round_keys=0, keys_full=0, group_done=0; key_ready=1 from the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over key_valid and step in the same cycle; a partial load or mid-SERVE bank is discarded and the next accepted key goes to slot 0.
REQ-028 key_ready SHALL be 0 while rst is high.

Verification
REQ-029 Reset, then stream keys k=0..23 with key_in=k+1 back-to-back -> keys_full rises after the 24th accept, round_keys[1151:1104]=1, round_keys[47:0]=24, count=0, key_ready=0.
REQ-030 Full bank, step pulsed 4 times with gaps -> count 0,1,2,3,0; group_done high exactly one cycle after the 4th step; key_ready=1 the next cycle.
REQ-031 key_valid toggled randomly during LOAD -> only cycles with key_valid=1 advance idx; slot order matches acceptance order with no skips or duplicates.
REQ-032 key_valid=1 held during SERVE with key_in=0xFFFF_FFFF_FFFF -> round_keys unchanged; step in LOAD -> count stays 0, no group_done.
REQ-033 rst asserted after 10 accepted keys, then 24 fresh keys -> first fresh key in [1151:1104], keys_full only after 24 new accepts.
REQ-034 rst asserted in SERVE at count=2 together with step -> state LOAD, count=0, keys_full=0, no group_done pulse.
